wb_arbiter: RTL

- Writeback scheduler for the register status table (RST).
- Collects completed results from NUM_FU functional units and grants one per cycle, round-robin, onto the common data bus (CDB).
- Drives the RST writeback port (wb_write/wb_sel/wb_tag) and the register-file write port.
- Suppresses busy-clear and regfile write for stale results, i.e. when the destination register has been re-dispatched to a newer tag.

---
 rtl/datapath_pkg.sv | 21 ++
 rtl/rr_arbiter.sv | 31 +++
 rtl/wb_arbiter.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/datapath_pkg.sv
// Shared datapath definitions: widths, the reserved "no producer" tag
// and the result record carried from a functional unit to writeback.
package datapath_pkg;

  localparam int NUM_FU   = 4;
  localparam int NUM_REGS = 32;
  localparam int REG_W    = $clog2(NUM_REGS);
  localparam int TAG_W    = 3;
  localparam int DATA_W   = 32;
  localparam int CNT_W    = 16;

  // Tag 0 means "no producer"; a result carrying it never clears busy.
  localparam logic [TAG_W-1:0] TAG_NONE = '0;

  typedef struct packed {
    logic [REG_W-1:0]  sel;
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
  } fu_result_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requester at or above ptr,
// wrapping from NUM_FU-1 back to 0. Shared with the dispatch issue logic.
module rr_arbiter #(
  parameter int NUM_FU = 4,
  localparam int IDX_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1
) (
  input  logic [NUM_FU-1:0] req,
  input  logic [IDX_W-1:0]  ptr,
  output logic [NUM_FU-1:0] gnt,
  output logic [IDX_W-1:0]  gnt_idx,
  output logic              any
);

  // Walk the requesters starting at ptr and take the first one found.
  always_comb begin
    logic [IDX_W-1:0] idx;
    idx     = '0;
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    for (int k = 0; k < NUM_FU; k++) begin
      idx = IDX_W'((int'(ptr) + k) % NUM_FU);
      if (!any && req[idx]) begin
        any      = 1'b1;
        gnt[idx] = 1'b1;
        gnt_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback scheduler: buffers one result per functional unit, grants one
// per cycle round-robin onto the CDB, and retires it into the RST and
// register file unless the destination has since been re-dispatched.
module wb_arbiter #(
  parameter int NUM_FU   = 4,
  parameter int NUM_REGS = 32,
  parameter int TAG_W    = 3,
  parameter int DATA_W   = 32,
  parameter int CNT_W    = 16,
  localparam int REG_W   = $clog2(NUM_REGS),
  localparam int PTR_W   = (NUM_FU > 1) ? $clog2(NUM_FU) : 1
) (
  input  logic                       CLK,
  input  logic                       nRST,
  input  logic                       flush,
  input  logic [NUM_FU-1:0]          fu_valid,
  output logic [NUM_FU-1:0]          fu_ready,
  input  logic [NUM_FU*REG_W-1:0]    fu_sel,
  input  logic [NUM_FU*TAG_W-1:0]    fu_tag,
  input  logic [NUM_FU*DATA_W-1:0]   fu_data,
  input  logic [NUM_REGS-1:0]        rst_busy,
  input  logic [NUM_REGS*TAG_W-1:0]  rst_tag,
  input  logic                       di_write,
  input  logic [REG_W-1:0]           di_sel,
  output logic                       cdb_valid,
  output logic [TAG_W-1:0]           cdb_tag,
  output logic [DATA_W-1:0]          cdb_data,
  output logic                       wb_write,
  output logic [REG_W-1:0]           wb_sel,
  output logic [TAG_W-1:0]           wb_tag,
  output logic                       rf_write,
  output logic [REG_W-1:0]           rf_sel,
  output logic [DATA_W-1:0]          rf_data,
  output logic [CNT_W-1:0]           stale_cnt
);

  import datapath_pkg::*;

  // Buffer entries use the shared record, so the widths above must stay
  // in step with the package defaults.
  fu_result_t        buf_q [NUM_FU];
  logic [NUM_FU-1:0] buf_valid;
  logic [PTR_W-1:0]  rr_ptr;

  logic [NUM_FU-1:0] gnt;
  logic [PTR_W-1:0]  gnt_idx;
  logic              gnt_any;

  fu_result_t        out_q;
  logic              out_valid;

  logic              sel_busy;
  logic [TAG_W-1:0]  sel_tag;
  logic              di_hit;
  logic              match;

  rr_arbiter #(.NUM_FU(NUM_FU)) u_rr (
    .req     (buf_valid),
    .ptr     (rr_ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .any     (gnt_any)
  );

  // A buffer can take a new result when empty or being drained this edge.
  assign fu_ready = (~buf_valid | gnt) & {NUM_FU{nRST & ~flush}};

  // Capture accepted results; a granted buffer empties unless refilled.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      buf_valid <= '0;
      for (int i = 0; i < NUM_FU; i++) buf_q[i] <= '0;
    end else if (flush) begin
      buf_valid <= '0;
    end else begin
      for (int i = 0; i < NUM_FU; i++) begin
        if (fu_valid[i] && fu_ready[i]) begin
          buf_valid[i]  <= 1'b1;
          buf_q[i].sel  <= fu_sel[i*REG_W +: REG_W];
          buf_q[i].tag  <= fu_tag[i*TAG_W +: TAG_W];
          buf_q[i].data <= fu_data[i*DATA_W +: DATA_W];
        end else if (gnt[i]) begin
          buf_valid[i] <= 1'b0;
        end
      end
    end
  end

  // Move the winning entry into the broadcast register.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      out_valid <= 1'b0;
      out_q     <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else begin
      out_valid <= gnt_any;
      if (gnt_any) out_q <= buf_q[gnt_idx];
    end
  end

  // Advance the round-robin pointer past the most recent winner.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      rr_ptr <= '0;
    end else if (!flush && gnt_any) begin
      rr_ptr <= (gnt_idx == PTR_W'(NUM_FU - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

  // Look up the RST entry addressed by the broadcast result.
  always_comb begin
    sel_busy = 1'b0;
    sel_tag  = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      if (out_q.sel == REG_W'(r)) begin
        sel_busy = rst_busy[r];
        sel_tag  = rst_tag[r*TAG_W +: TAG_W];
      end
    end
  end

  // A dispatch to the same register this cycle supersedes the retirement.
  assign di_hit = di_write & (di_sel == out_q.sel);
  assign match  = out_valid & sel_busy & (sel_tag == out_q.tag) &
                  (out_q.tag != TAG_NONE) & ~di_hit;

  // Count broadcasts whose writeback was suppressed, saturating at max.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      stale_cnt <= '0;
    end else if (out_valid && !match && (stale_cnt != '1)) begin
      stale_cnt <= stale_cnt + 1'b1;
    end
  end

  assign cdb_valid = out_valid;
  assign cdb_tag   = out_q.tag;
  assign cdb_data  = out_q.data;
  assign wb_write  = match;
  assign wb_sel    = out_q.sel;
  assign wb_tag    = out_q.tag;
  assign rf_write  = match;
  assign rf_sel    = out_q.sel;
  assign rf_data   = out_q.data;

endmodule
